multiplier_seq_u: RTL and testbench



---
 rtl/multiplier_seq_u_pkg.sv | 18 +
 rtl/multiplier_seq_u_control.sv | 55 +++++
 rtl/multiplier_seq_u.sv | 58 +++++
 tb/tb_multiplier_seq_u.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/multiplier_seq_u_pkg.sv
// Shared definitions for the sequential unsigned multiplier: FSM state encodings
// and the default operand width.
`ifndef MULTIPLIER_SEQ_U_PKG_SV
`define MULTIPLIER_SEQ_U_PKG_SV

package multiplier_seq_u_pkg;

    localparam int MUL_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

`endif

// File: rtl/multiplier_seq_u_control.sv
// Control FSM and step counter for the shift-add multiplier: decides when the
// datapath loads operands and when it takes one shift-add step.
module multiplier_seq_u_control
    import multiplier_seq_u_pkg::*;
#(
    parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic load,
    output logic step,
    output logic done,
    output logic busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    mul_state_e    state_reg;
    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= MUL_IDLE;
            count_reg <= '0;
        end else begin
            case (state_reg)
                MUL_IDLE, MUL_DONE: begin
                    if (start) begin
                        state_reg <= MUL_BUSY;
                        count_reg <= '0;
                    end
                end
                MUL_BUSY: begin
                    count_reg <= count_reg + 1'b1;
                    // The step taken while count is WIDTH-1 is the last of WIDTH steps.
                    if (count_reg == LAST_STEP) begin
                        state_reg <= MUL_DONE;
                    end
                end
                default: begin
                    state_reg <= MUL_IDLE;
                    count_reg <= '0;
                end
            endcase
        end
    end

    assign load = start && ((state_reg == MUL_IDLE) || (state_reg == MUL_DONE));
    assign step = (state_reg == MUL_BUSY);
    assign done = (state_reg == MUL_DONE);
    assign busy = (state_reg == MUL_BUSY);

endmodule

// File: rtl/multiplier_seq_u.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per clock,
// WIDTH-cycle fixed latency, 2*WIDTH-bit product held while finish is high.
module multiplier_seq_u
    import multiplier_seq_u_pkg::*;
#(
    parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               finish
);

    logic             load;
    logic             step;
    logic             done;
    logic [WIDTH-1:0] m_reg;
    logic [2*WIDTH:0] p_reg;
    logic [WIDTH:0]   sum;

    multiplier_seq_u_control #(
        .WIDTH (WIDTH)
    ) u_control (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .load  (load),
        .step  (step),
        .done  (done),
        .busy  (busy)
    );

    // The carry bit p_reg[2*WIDTH] is always zero between steps, so the top
    // WIDTH+1 bits are exactly the zero-extended high half.
    always_comb begin
        sum = p_reg[2*WIDTH:WIDTH] + (p_reg[0] ? {1'b0, m_reg} : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            m_reg <= '0;
            p_reg <= '0;
        end else if (load) begin
            m_reg <= a;
            p_reg <= {{(WIDTH + 1){1'b0}}, b};
        end else if (step) begin
            p_reg <= {1'b0, sum, p_reg[WIDTH-1:1]};
        end
    end

    assign product = p_reg[2*WIDTH-1:0];
    assign finish  = done;

endmodule

// File: tb/tb_multiplier_seq_u.sv
// Self-checking bench for multiplier_seq_u: directed vectors plus a cycle-level
// reference model compared against the DUT on every falling edge.
module tb_multiplier_seq_u;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2*W-1:0] product;
    logic          busy;
    logic          finish;

    int checks = 0;
    int errors = 0;

    multiplier_seq_u #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .finish  (finish)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a multiply takes W cycles and yields a*b.
    logic          m_valid = 1'b0;
    logic          m_busy;
    logic          m_finish;
    logic          m_known;
    logic [63:0]   m_prod;
    int            m_left;

    always @(posedge clk) begin
        if (!rst) begin
            m_valid  <= 1'b1;
            m_busy   <= 1'b0;
            m_finish <= 1'b0;
            m_known  <= 1'b1;
            m_prod   <= '0;
            m_left   <= 0;
        end else if (m_valid) begin
            if (!m_busy && start) begin
                m_busy   <= 1'b1;
                m_finish <= 1'b0;
                m_known  <= 1'b0;
                m_prod   <= 64'(a) * 64'(b);
                m_left   <= W;
            end else if (m_busy) begin
                if (m_left == 1) begin
                    m_busy   <= 1'b0;
                    m_finish <= 1'b1;
                    m_known  <= 1'b1;
                end
                m_left <= m_left - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_busy", 64'(busy), 64'(m_busy));
            chk("model_finish", 64'(finish), 64'(m_finish));
            if (m_known) chk("model_product", product, m_prod);
        end
    end

    // Start a multiply, scramble the operand inputs afterwards, optionally poke
    // a second start at cycle poke_at, and wait (bounded) for finish.
    task automatic run_mul(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                           input logic [63:0] exp, input string name,
                           input int poke_at, input logic [W-1:0] pa, input logic [W-1:0] pb);
        int c;
        start = 1'b1;
        a = ta;
        b = tb2;
        @(negedge clk);
        chk({name, "_finish_drop"}, 64'(finish), 64'd0);
        start = 1'b0;
        a = ~ta;
        b = ~tb2;
        c = 0;
        while (!finish && c < 100) begin
            if (c == poke_at) begin
                start = 1'b1;
                a = pa;
                b = pb;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        chk({name, "_latency"}, 64'(c), 64'd32);
        chk(name, product, exp);
        $display("mul %s a=%h b=%h product=%h cycles=%0d", name, ta, tb2, product, c);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_finish", 64'(finish), 64'd0);
        chk("reset_product", product, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        run_mul(32'd7, 32'd6, 64'd42, "basic", -1, '0, '0);
        repeat (5) @(negedge clk);
        chk("hold_product", product, 64'd42);
        chk("hold_finish", 64'(finish), 64'd1);

        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, "max", -1, '0, '0);
        run_mul(32'd0, 32'h12345678, 64'd0, "zero", -1, '0, '0);
        run_mul(32'h80000000, 32'd2, 64'h1_00000000, "msb", -1, '0, '0);
        run_mul(32'd65535, 32'd65537, 64'hFFFFFFFF, "fermat", -1, '0, '0);
        run_mul(32'd1, 32'hFFFFFFFF, 64'hFFFFFFFF, "identity", -1, '0, '0);
        run_mul(32'd3, 32'd5, 64'd15, "ignore_start", 9, 32'd9, 32'd9);
        run_mul(32'd100, 32'd100, 64'd10000, "restart", -1, '0, '0);

        // Reset in the middle of an operation.
        start = 1'b1;
        a = 32'd1000;
        b = 32'd1000;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_finish", 64'(finish), 64'd0);
        chk("midreset_product", product, 64'd0);
        $display("mul midreset a=%h b=%h product=%h", 32'd1000, 32'd1000, product);
        @(negedge clk);
        run_mul(32'd1000, 32'd1000, 64'd1000000, "after_reset", -1, '0, '0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
